// File: rtl/param_load_ctrl_pkg.sv
// Shared definitions for the parameter loader: FSM encoding and core-select constants.
package param_load_ctrl_pkg;

    // Width of the core-select bus driven towards the grid.
    localparam int unsigned CORE_SEL_W = 3;

    // Core-select value meaning "no core selected".
    localparam logic [CORE_SEL_W-1:0] CORE_NONE = 3'd0;

    // Core-select value of the first core of a run.
    localparam logic [CORE_SEL_W-1:0] CORE_FIRST = 3'd1;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT_EN = 3'd3,
        ST_FINISH  = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/param_load_ctrl.sv
// Parameter loader: streams WORDS_PER_CORE source words into the grid parameter
// FIFO for each of NUM_CORES cores in turn, waiting for the grid to acknowledge
// every core before moving on, with a timeout on that acknowledge.
module param_load_ctrl
    import param_load_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 6,
    parameter int unsigned WORDS_PER_CORE = 256,
    parameter int unsigned PARAM_W        = 368,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic                                    src_valid,
    input  logic [PARAM_W-1:0]                      src_data,
    output logic                                    src_ready,
    output logic [CORE_SEL_W-1:0]                   next_core,
    output logic [PARAM_W-1:0]                      parameter_in,
    output logic                                    param_winc,
    input  logic                                    param_wfull,
    input  logic                                    next_core_en,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic [$clog2(WORDS_PER_CORE+1)-1:0]     word_cnt
);

    localparam int unsigned WCNT_W = $clog2(WORDS_PER_CORE + 1);
    localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_CORE - 1);
    localparam logic [CORE_W-1:0] CORE_LAST = CORE_W'(NUM_CORES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t            state;
    logic [CORE_W-1:0] core_idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              xfer;

    // A word moves only while streaming, with source data present and room in the
    // FIFO; reset and abort suppress it so a discarded core never gets a stray write.
    assign xfer         = reset_n & ~abort & (state == ST_STREAM) & src_valid & ~param_wfull;
    assign param_winc   = xfer;
    assign src_ready    = xfer;
    assign parameter_in = src_data;

    // Loader FSM with its word counter, timeout counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            core_idx  <= '0;
            word_cnt  <= '0;
            tmo_cnt   <= '0;
            next_core <= CORE_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort wins over everything; err survives so a timeout stays visible.
                state     <= ST_IDLE;
                core_idx  <= '0;
                word_cnt  <= '0;
                tmo_cnt   <= '0;
                next_core <= CORE_NONE;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (start) begin
                            state     <= ST_SELECT;
                            core_idx  <= '0;
                            word_cnt  <= '0;
                            tmo_cnt   <= '0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            next_core <= CORE_FIRST;
                        end
                    end
                    ST_SELECT: begin
                        state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (xfer) begin
                            word_cnt <= word_cnt + WCNT_W'(1);
                            if (word_cnt == WCNT_LAST) begin
                                state   <= ST_WAIT_EN;
                                tmo_cnt <= '0;
                            end
                        end
                    end
                    ST_WAIT_EN: begin
                        // An acknowledge on the last timeout cycle still counts.
                        if (next_core_en) begin
                            if (core_idx < CORE_LAST) begin
                                state     <= ST_SELECT;
                                core_idx  <= core_idx + CORE_W'(1);
                                word_cnt  <= '0;
                                next_core <= next_core + 3'd1;
                            end else begin
                                state <= ST_FINISH;
                                done  <= 1'b1;
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    ST_FINISH: begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        next_core <= CORE_NONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_load_ctrl.sv
// Bench for param_load_ctrl: vector table for the first core handshakes, plus
// hand-written run sequences; written words are checked against a scoreboard queue.
module tb_param_load_ctrl;

    localparam int NC = 6;
    localparam int W  = 4;
    localparam int TO = 16;
    localparam int PW = 368;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          src_valid = 1'b0;
    logic [PW-1:0] src_data = '0;
    logic          param_wfull = 1'b0;
    logic          next_core_en = 1'b0;
    logic          src_ready;
    logic [2:0]    next_core;
    logic [PW-1:0] parameter_in;
    logic          param_winc;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    word_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_wr  = 0;
    int            wr_core [8];
    int            k = 0;
    bit            took = 1'b0;
    bit            mon_on = 1'b0;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] e_w;

    typedef struct {
        logic       st, ab, v, wf, en;
        logic       busy;
        logic [2:0] nc;
        logic       winc;
        logic [2:0] wc;
        logic       done, err;
    } vec_t;

    vec_t tbl [15];

    param_load_ctrl #(
        .NUM_CORES      (NC),
        .WORDS_PER_CORE (W),
        .PARAM_W        (PW),
        .TIMEOUT        (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .next_core    (next_core),
        .parameter_in (parameter_in),
        .param_winc   (param_winc),
        .param_wfull  (param_wfull),
        .next_core_en (next_core_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk_word(input int n);
        logic [PW-1:0] w;
        for (int i = 0; i < PW / 8; i++) w[i*8 +: 8] = 8'(n * 7 + i + 1);
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and present the next source word.
    task automatic tick();
        @(posedge clk);
        #1;
        if (took) k++;
        src_data = mk_word(k);
    endtask

    task automatic new_run();
        exp_q.delete();
        k = 0;
        took = 1'b0;
        n_wr = 0;
        for (int c = 0; c < 8; c++) wr_core[c] = 0;
        for (int i = 0; i < NC * W; i++) exp_q.push_back(mk_word(i));
    endtask

    // Scoreboard and handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            took = param_winc;
            chk("ready_eq_winc", 64'(src_ready), 64'(param_winc));
            chk("ready_without_valid", 64'(src_ready & ~src_valid), 64'd0);
            if (param_winc === 1'b1) begin
                n_wr++;
                wr_core[next_core]++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra_write: got word %h with nothing expected", parameter_in);
                end else begin
                    e_w = exp_q.pop_front();
                    if (parameter_in !== e_w) begin
                        n_err++;
                        $display("FAIL sb_word: got %h expected %h", parameter_in, e_w);
                    end
                end
            end
        end
    end

    // Full run from start (or restart from ERROR) to the done pulse.
    task automatic do_run(input int stall_core, input bit toggle_v, input bit hold_start, input string tag);
        int wait_cyc = 0;
        int dones = 0;
        int last_nc = 0;
        int stall_left = 0;
        int done_cyc = -10;
        int frozen_wc = 0;
        bit stalled = 1'b0;
        bit finished = 1'b0;
        new_run();
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            tick();
            start        = hold_start ? 1'b1 : (cyc == 0);
            abort        = 1'b0;
            src_valid    = toggle_v ? (cyc % 2 == 0) : 1'b1;
            param_wfull  = (stall_left > 0);
            next_core_en = (wait_cyc >= 2);
            @(negedge clk);
            if (cyc == 1)
                chk({tag, "_launch"}, 64'({busy, next_core, err, word_cnt}), 64'({1'b1, 3'd1, 1'b0, 3'd0}));
            if (param_wfull) begin
                chk({tag, "_stall"}, 64'({param_winc, src_ready, word_cnt}), 64'({2'b00, 3'(frozen_wc)}));
                stall_left--;
            end
            if (cyc >= 1 && dones == 0 && next_core != 3'd0 && next_core != 3'(last_nc)) begin
                chk({tag, "_step"}, 64'(next_core), 64'(last_nc + 1));
                last_nc = int'(next_core);
            end
            if (!stalled && stall_core != 0 && busy && next_core == 3'(stall_core) && word_cnt == 3'd1) begin
                stalled    = 1'b1;
                stall_left = 5;
                frozen_wc  = int'(word_cnt) + int'(param_winc);
            end
            wait_cyc = (busy && !done && word_cnt == 3'(W)) ? wait_cyc + 1 : 0;
            if (cyc == done_cyc + 1)
                chk({tag, "_after_done"}, 64'({busy, done, next_core}), 64'd0);
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk({tag, "_busy_with_done"}, 64'({busy, next_core}), 64'({1'b1, 3'(NC)}));
            end
            if (cyc == done_cyc + 2) begin
                if (hold_start)
                    chk({tag, "_restart"}, 64'({busy, next_core}), 64'({1'b1, 3'd1}));
                finished = 1'b1;
            end
        end
        start = 1'b0; src_valid = 1'b0; param_wfull = 1'b0; next_core_en = 1'b0;
        chk({tag, "_completed"}, 64'(finished), 64'd1);
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        chk({tag, "_last_core"}, 64'(last_nc), 64'(NC));
        chk({tag, "_writes"}, 64'(n_wr), 64'(NC * W));
        chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
        for (int c = 1; c <= NC; c++)
            chk($sformatf("%s_core%0d_writes", tag, c), 64'(wr_core[c]), 64'(W));
        if (stall_core != 0) chk({tag, "_stall_seen"}, 64'(stalled), 64'd1);
    endtask

    // Start a run and stream until a given core/word point is about to be crossed.
    task automatic run_until(input int core, input int wc, output bit hit);
        int wait_cyc = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
            tick();
            start = (cyc == 0); abort = 1'b0; param_wfull = 1'b0; src_valid = 1'b1;
            next_core_en = (wait_cyc >= 2);
            @(negedge clk);
            wait_cyc = (busy && !done && word_cnt == 3'(W)) ? wait_cyc + 1 : 0;
            if (busy && next_core == 3'(core) && word_cnt == 3'(wc) && param_winc) hit = 1'b1;
        end
        start = 1'b0; next_core_en = 1'b0;
    endtask

    initial begin
        bit hit;
        bit err_seen;
        int wait_cyc;

        //            st ab v  wf en  busy nc winc wc done err
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};

        // Reset state.
        reset_n = 1'b0;
        tick();
        tick();
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'({busy, next_core, param_winc, src_ready, done, err, word_cnt}), 64'd0);
        reset_n = 1'b1;

        // Vector table: first core handshakes, stall, start-while-busy, abort.
        new_run();
        for (int i = 0; i < 15; i++) begin
            tick();
            start = tbl[i].st; abort = tbl[i].ab; src_valid = tbl[i].v;
            param_wfull = tbl[i].wf; next_core_en = tbl[i].en;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'({busy, next_core, param_winc, word_cnt, done, err}),
                64'({tbl[i].busy, tbl[i].nc, tbl[i].winc, tbl[i].wc, tbl[i].done, tbl[i].err}));
        end
        chk("vec_writes", 64'(n_wr), 64'd5);
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; param_wfull = 1'b0; next_core_en = 1'b0;

        do_run(0, 1'b0, 1'b0, "basic");
        do_run(3, 1'b0, 1'b0, "stall");
        do_run(0, 1'b1, 1'b0, "toggle");

        // Acknowledge withheld in core 2 until the timeout fires.
        new_run();
        wait_cyc = 0;
        err_seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !err_seen; cyc++) begin
            tick();
            start = (cyc == 0); src_valid = 1'b1;
            next_core_en = (wait_cyc >= 2 && next_core == 3'd1);
            @(negedge clk);
            if (err) begin
                err_seen = 1'b1;
                chk("tmo_wait_cycles", 64'(wait_cyc), 64'(TO));
                chk("tmo_state", 64'({busy, next_core}), 64'({1'b0, 3'd2}));
            end
            wait_cyc = (busy && !done && word_cnt == 3'(W)) ? wait_cyc + 1 : 0;
        end
        chk("tmo_reached", 64'(err_seen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0; next_core_en = 1'b0; src_valid = 1'b1;
            @(negedge clk);
            chk("err_hold", 64'({err, busy, next_core, param_winc}), 64'({1'b1, 1'b0, 3'd2, 1'b0}));
        end
        chk("tmo_writes", 64'(n_wr), 64'(2 * W));
        do_run(0, 1'b0, 1'b0, "reload");

        // Abort with two words of core 4 written.
        new_run();
        run_until(4, 1, hit);
        chk("abort_point_reached", 64'(hit), 64'd1);
        tick();
        abort = 1'b1; src_valid = 1'b0;
        @(negedge clk);
        chk("abort_cycle", 64'({busy, next_core, word_cnt, param_winc}), 64'({1'b1, 3'd4, 3'd2, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            tick();
            abort = 1'b0; src_valid = 1'b1;
            @(negedge clk);
            chk("post_abort", 64'({busy, next_core, word_cnt, param_winc, src_ready}), 64'd0);
        end
        chk("abort_writes", 64'(n_wr), 64'(3 * W + 2));

        // Reset in the middle of core 2.
        new_run();
        run_until(2, 1, hit);
        chk("reset_point_reached", 64'(hit), 64'd1);
        tick();
        reset_n = 1'b0; src_valid = 1'b1;
        @(negedge clk);
        chk("reset_cycle_no_write", 64'({param_winc, src_ready}), 64'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs", 64'({busy, next_core, param_winc, src_ready, done, err, word_cnt}), 64'd0);
        chk("reset_writes", 64'(n_wr), 64'(W + 2));
        src_valid = 1'b0;

        // Start held high throughout, then clean up the run it relaunches.
        do_run(0, 1'b0, 1'b1, "hold_start");
        tick();
        abort = 1'b1;
        @(negedge clk);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("final_idle", 64'({busy, next_core, param_winc}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_load_ctrl.md
PARAM_LOAD_CTRL -- requirements
Module: param_load_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CORES default 6, number of cores loaded per run.
REQ-002 Parameters SHALL be: WORDS_PER_CORE default 256, parameter words per core.
REQ-003 Parameters SHALL be: PARAM_W default 368, parameter word width.
REQ-004 Parameters SHALL be: TIMEOUT default 1024, WAIT_EN cycle limit.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low.
REQ-006 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin run (level, sampled in IDLE).
- abort  in  1  return to IDLE.
- src_valid  in  1  source word valid.
- src_data  in  PARAM_W  source word.
- src_ready  out  1  source word consumed.
- next_core  out  3  selected core, 1..NUM_CORES; 0 = none.
- parameter_in  out  PARAM_W  word to grid.
- param_winc  out  1  grid parameter FIFO write.
- param_wfull  in  1  grid parameter FIFO full.
- next_core_en  in  1  grid acknowledges current core loaded.
- busy  out  1  run in progress.
- done  out  1  one-cycle run-complete pulse.
- err  out  1  timeout flag.
- word_cnt  out  clog2(WORDS_PER_CORE+1)  words sent to current core.

Function
REQ-007 States SHALL be IDLE, SELECT, STREAM, WAIT_EN, FINISH, ERROR.
REQ-008 IDLE->SELECT SHALL occur when start=1; core_idx and word_cnt clear to 0 and err clears.
REQ-009 SELECT SHALL last exactly 1 cycle with next_core=core_idx+1, then go to STREAM.
REQ-010 In STREAM, param_winc and src_ready SHALL both equal src_valid & ~param_wfull, combinationally, same cycle.
REQ-011 parameter_in SHALL equal src_data combinationally (no added latency).
REQ-012 Each transfer SHALL increment word_cnt; the transfer making word_cnt==WORDS_PER_CORE SHALL move the FSM to WAIT_EN on the next edge.
REQ-013 No writes SHALL occur outside STREAM; param_wfull=1 SHALL stall with no write and no count.
REQ-014 WAIT_EN SHALL sample next_core_en (level); a timeout counter increments each cycle.
- next_core_en=1 and core_idx<NUM_CORES-1: core_idx increments, word_cnt clears, go to SELECT.
- next_core_en=1 and core_idx==NUM_CORES-1: go to FINISH.
REQ-015 Timeout counter reaching TIMEOUT-1 without next_core_en SHALL go to ERROR; next_core_en in that same cycle takes priority.
REQ-016 FINISH SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-017 ERROR SHALL hold err=1 and next_core unchanged until abort or start.
- start goes to SELECT with fresh counters.
- abort goes to IDLE.
REQ-018 abort=1 in any state SHALL force IDLE on the next edge and override start; err is retained only when leaving ERROR via abort.
REQ-019 start while busy SHALL be ignored.
REQ-020 busy SHALL be 1 in SELECT, STREAM, WAIT_EN and FINISH.
REQ-021 next_core SHALL be 0 in IDLE and core_idx+1 in SELECT, STREAM, WAIT_EN and FINISH.

Reset
REQ-022 On reset_n=0 at a clk edge, the following SHALL all be 0 and the state SHALL be IDLE: next_core, param_winc, src_ready, busy, done, err, word_cnt, core_idx, timeout counter.
REQ-023 Reset mid-STREAM SHALL discard the partial core; no write occurs in the reset cycle.

Structure
REQ-024 State encoding and the next_core "none" value (0) SHALL live in the shared SNN package.
REQ-025 No sub-module SHALL be instantiated; the FSM, word counter and timeout counter are local.

Verification
REQ-026 Sim params NUM_CORES=6, WORDS_PER_CORE=4, TIMEOUT=16 SHALL be used for the following scenarios.
REQ-027 start, src_valid always 1, wfull 0, next_core_en 2 cycles after each WAIT_EN entry -> next_core steps 1..6, 24 writes total in data order, single done pulse, busy falls the same cycle done falls.
REQ-028 param_wfull=1 for 5 cycles mid-core 3 -> no writes or src_ready during the stall, word_cnt frozen, word order unbroken.
REQ-029 src_valid toggles every cycle -> exactly 4 writes per core, src_ready never without src_valid.
REQ-030 next_core_en held 0 in core 2 -> err=1 after 16 WAIT_EN cycles with next_core=2; then start -> reload from core 1.
REQ-031 abort while word_cnt=2 of core 4 -> IDLE next cycle, next_core=0, no further writes; reset_n=0 mid-stream -> all outputs 0.
REQ-032 start held high through the whole run -> ignored while busy; a new run begins the cycle after returning to IDLE.
